md_unit_32bit: RTL and testbench
================================

# md_unit_32bit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the same register-file operands (`rs1_i`, `rs2_i`) as the bitwise logic units. It produces a 32-bit `rd_o` for the write-back mux. Operations run over multiple cycles using a start/busy/done handshake, and the control unit stalls the PC while `busy_o` is high.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk_i`  input  1  single clock; all state updates on rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `start_i`  input  1  request; accepted only in IDLE.
- `funct3_i`  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i`  input  32  operand A (multiplicand / dividend).
- `rs2_i`  input  32  operand B (multiplier / divisor).
- `busy_o`  output  1  high while iterating.
- `done_o`  output  1  one-cycle pulse; `rd_o` is valid in that cycle.
- `rd_o`  output  32  result; held until the next DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY: `start_i`=1, normal case.
  - IDLE→DONE: `start_i`=1, special case.
  - BUSY→DONE: iteration counter reaches 31.
  - DONE→IDLE: unconditional.
- On accept, register `funct3_i`, `rs1_i` and `rs2_i`. Input changes after the accept cycle are ignored.
- Operand signedness:
  - Signed: both operands for MULH, DIV, REM; `rs1_i` only for MULHSU.
  - Unsigned: both operands for MUL, MULHU, DIVU, REMU.
  - On accept, record the sign of each signed operand, then convert that operand to its magnitude.
- Multiply: radix-2 shift-add over magnitudes, 1 bit per cycle, 64-bit product register.
  - At DONE, negate the product if the result sign is negative.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring division over magnitudes, 1 quotient bit per cycle, 33-bit partial remainder.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Special cases skip BUSY and go straight to DONE:
  - Divisor = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `rs1_i`.
  - DIV with A = 0x80000000 and B = 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- A `start_i` in BUSY or DONE is ignored and not queued.
- Reset in any state (including mid-BUSY):
  - Next state IDLE, counter 0.
  - `busy_o`=0, `done_o`=0, `rd_o`=0.
  - No done pulse for the aborted op.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `rd_o`=0x00000000, state IDLE.
- Normal op, with `start_i` sampled high in cycle 0 (IDLE):
  - Cycles 1–32: BUSY, `busy_o`=1.
  - Cycle 33: DONE, `done_o`=1, `busy_o`=0, `rd_o` valid.
  - Cycle 34: IDLE; earliest next accept.
- Special case: DONE in cycle 1, IDLE in cycle 2.
- `rd_o` is registered and changes only on the DONE entry edge (or on reset).
- `busy_o` and `done_o` are decoded from registered state, so they carry no combinational path from the inputs.
- Back-to-back throughput: one op per 34 cycles (normal), one per 2 cycles (special).

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `rd_o`=0xFFFFFFEB in cycle 33; `busy_o` high for exactly 32 cycles; `done_o` high for exactly 1 cycle.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide 0xFFFFFFF9 (−7) by 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases, each with `done_o` in cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 0x12345678 / 0 → 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Start MUL; pulse `start_i` with new operands in cycle 10 and toggle `rs1_i` throughout:
  - First result unaffected.
  - No second op launched.
- Assert `rst_i` in cycle 15 of a DIV:
  - Next cycle `busy_o`=0, `rd_o`=0, and `done_o` never pulses.
  - A new MUL 3 × 4 started afterwards returns 12 after 33 cycles.

Source files
------------

// File: rtl/md_unit_32bit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_32bit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide over operand magnitudes, one
//               bit per cycle, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit_32bit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rd_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] C_LAST_ITER = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic [63:0] r_prod;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_rd;

    // Accept-time operand decode: signedness, magnitudes, special cases.
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_in_sign_a;
    logic        w_in_sign_b;
    logic [31:0] w_in_mag_a;
    logic [31:0] w_in_mag_b;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_special_rd;

    assign w_a_signed  = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                         (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign w_b_signed  = (funct3_i == 3'b001) | (funct3_i == 3'b100) |
                         (funct3_i == 3'b110);
    assign w_in_sign_a = w_a_signed & rs1_i[31];
    assign w_in_sign_b = w_b_signed & rs2_i[31];
    assign w_in_mag_a  = w_in_sign_a ? (~rs1_i + 32'd1) : rs1_i;
    assign w_in_mag_b  = w_in_sign_b ? (~rs2_i + 32'd1) : rs2_i;

    // Signed overflow only exists for DIV/REM (funct3 bit 0 clear).
    assign w_div_zero  = funct3_i[2] & (rs2_i == 32'd0);
    assign w_div_ovf   = funct3_i[2] & ~funct3_i[0] &
                         (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
    assign w_special   = w_div_zero | w_div_ovf;
    assign w_special_rd = w_div_zero ? (funct3_i[1] ? rs1_i : 32'hFFFF_FFFF)
                                     : (funct3_i[1] ? 32'd0 : 32'h8000_0000);

    // One multiply step: the low half of the product register holds the
    // not-yet-consumed multiplier bits, the high half accumulates.
    logic [32:0] w_add;
    logic [63:0] w_prod_nxt;
    assign w_add      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mag_a} : 33'd0);
    assign w_prod_nxt = {w_add, r_prod[31:1]};

    // One restoring-divide step: 33-bit trial remainder against the divisor.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_mag_b};
    assign w_fits    = ~w_diff[32];
    assign w_rem_nxt = w_fits ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_fits};

    // Final sign fix-up, evaluated on the last iteration so rd is
    // registered on the DONE entry edge.
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_result;
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~w_prod_nxt + 64'd1) : w_prod_nxt;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
    assign w_rem_fix  = r_sign_a ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

    // Result select by the captured operation.
    always_comb begin
        w_result = w_prod_fix[31:0];
        case (r_op)
            3'b000:                 w_result = w_prod_fix[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_fix[63:32];
            3'b100, 3'b101:         w_result = w_quo_fix;
            default:                w_result = w_rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = w_special ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == C_LAST_ITER) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in BUSY, register the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= 32'd0;
            r_mag_b  <= 32'd0;
            r_prod   <= 64'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_rd     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cnt    <= 5'd0;
                        r_op     <= funct3_i;
                        r_sign_a <= w_in_sign_a;
                        r_sign_b <= w_in_sign_b;
                        r_mag_a  <= w_in_mag_a;
                        r_mag_b  <= w_in_mag_b;
                        r_prod   <= {32'd0, w_in_mag_b};
                        r_quo    <= w_in_mag_a;
                        r_rem    <= 32'd0;
                        if (w_special) r_rd <= w_special_rd;
                    end
                end
                S_BUSY: begin
                    r_cnt  <= r_cnt + 5'd1;
                    r_prod <= w_prod_nxt;
                    r_quo  <= w_quo_nxt;
                    r_rem  <= w_rem_nxt;
                    if (r_cnt == C_LAST_ITER) r_rd <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state == S_BUSY);
    assign done_o = (r_state == S_DONE);
    assign rd_o   = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit_32bit
// Description : Self-checking bench for md_unit_32bit against an arithmetic
//               reference model built on 64-bit integer math.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit_32bit;

    localparam logic [2:0] C_MUL    = 3'b000;
    localparam logic [2:0] C_MULH   = 3'b001;
    localparam logic [2:0] C_MULHSU = 3'b010;
    localparam logic [2:0] C_MULHU  = 3'b011;
    localparam logic [2:0] C_DIV    = 3'b100;
    localparam logic [2:0] C_DIVU   = 3'b101;
    localparam logic [2:0] C_REM    = 3'b110;
    localparam logic [2:0] C_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] rd;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd;

    md_unit_32bit dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (f3),
        .rs1_i    (a),
        .rs2_i    (b),
        .busy_o   (busy),
        .done_o   (done),
        .rd_o     (rd)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics via wide integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      uy;
        longint      p;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'd0, y});
        pu = {32'd0, x} * {32'd0, y};
        case (op)
            C_MUL:    return pu[31:0];
            C_MULH:   begin p = sx * sy; return p[63:32]; end
            C_MULHSU: begin p = sx * uy; return p[63:32]; end
            C_MULHU:  return pu[63:32];
            C_DIV: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                p = sx / sy;
                return p[31:0];
            end
            C_DIVU:   return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            C_REM: begin
                if (y == 32'd0) return x;
                p = sx % sy;
                return p[31:0];
            end
            default:  return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    // Issue one op from an IDLE cycle and check timing/result; returns in
    // the IDLE cycle following DONE. With disturb set, inputs are churned
    // and extra starts are issued in BUSY and DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit disturb);
        logic [31:0] exp;
        int          exp_cyc;
        int          c;
        int          busy_cnt;
        bit          held_ok;
        bit          seen;
        bit          quiet;
        exp     = ref_md(op, x, y);
        exp_cyc = (op[2] && (y == 32'd0 ||
                  (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 1 : 33;
        f3 = op; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; busy_cnt = 0; held_ok = 1'b1; seen = 1'b0;
        while (c <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (rd !== last_rd) held_ok = 1'b0;
                if (disturb) begin
                    a     = ~a;
                    start = (c == 10);
                    if (c == 10) begin
                        b  = $urandom;
                        f3 = 3'($urandom_range(0, 7));
                    end
                end
                @(posedge clk); #1;
                c++;
            end
        end
        total++;
        if (!seen || c != exp_cyc) begin
            bad++;
            $display("FAIL done_cycle op=%0d a=%h b=%h got=%0d want=%0d", op, x, y, seen ? c : -1, exp_cyc);
        end
        total++;
        if (rd !== exp) begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", op, x, y, rd, exp);
        end
        total++;
        if (busy_cnt != exp_cyc - 1) begin
            bad++;
            $display("FAIL busy_cycles op=%0d got=%0d want=%0d", op, busy_cnt, exp_cyc - 1);
        end
        total++;
        if (!held_ok) begin
            bad++;
            $display("FAIL rd_held op=%0d got=changed want=%h", op, last_rd);
        end
        if (disturb) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after op=%0d got busy=%b done=%b want 0/0", op, busy, done);
        end
        last_rd = exp;
        if (disturb) begin
            quiet = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
                if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
            end
            total++;
            if (!quiet) begin
                bad++;
                $display("FAIL no_second_op got=launched want=idle");
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; f3 = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=00000000", rd); end
        last_rd = 32'd0;
    endtask

    task automatic test_directed();
        run_op(C_MUL,    32'd7,         32'hFFFF_FFFD, 1'b0);
        run_op(C_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(C_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(C_DIV,    32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op(C_REM,    32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op(C_DIVU,   32'd100,       32'd7,         1'b0);
        run_op(C_REMU,   32'd100,       32'd7,         1'b0);
    endtask

    task automatic test_special();
        run_op(C_DIVU, 32'd5,         32'd0,         1'b0);
        run_op(C_REM,  32'h1234_5678, 32'd0,         1'b0);
        run_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(C_DIV,  32'hDEAD_BEEF, 32'd0,         1'b0);
        run_op(C_REMU, 32'hCAFE_F00D, 32'd0,         1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 9))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = {1'b1, 31'($urandom)};
                default: ;
            endcase
            run_op(op, x, y, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_op(C_DIVU, 32'd9,         32'd0,    1'b0);
        run_op(C_REMU, 32'd9,         32'd0,    1'b0);
        run_op(C_MULH, 32'hFFFF_0001, 32'd3,    1'b0);
        run_op(C_REM,  32'h8000_0001, 32'd1000, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op(C_MUL, 32'h0001_2345, 32'h0000_6789, 1'b1);
    endtask

    task automatic test_reset_mid_div();
        bit quiet;
        f3 = C_DIV; a = 32'h7654_3210; b = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_div_busy got=%b want=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL abort_rd got=%h want=00000000", rd); end
        quiet = 1'b1;
        repeat (40) begin
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL abort_no_done got=pulse want=none"); end
        last_rd = 32'd0;
        run_op(C_MUL, 32'd3, 32'd4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_back_to_back();
        test_ignore_start();
        test_random();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
